// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared state and traceback direction encodings for the Needleman-Wunsch core
//
// Purpose : state encodings for the sequence index generator FSM and the
//           traceback direction codes. The traceback unit also imports
//           this package.
// Ports   : none (package)
package nw_pkg;

   // Index generator FSM states
   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] FILL       = 2'd1;
   localparam logic [1:0] WAIT_TRACE = 2'd2;
   localparam logic [1:0] TRACE      = 2'd3;

   // Traceback move codes
   localparam logic [1:0] DIR_DIAG = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_LEFT = 2'b10;
   localparam logic [1:0] DIR_NONE = 2'b11;

endpackage

// File: rtl/nw_seq_index_gen_if.sv
// rtl/nw_seq_index_gen_if.sv - control and counter/index bundle of the sequence index generator
//
// Purpose : groups the control inputs and the counter/index outputs of
//           nw_seq_index_gen.
// Params  : AW - A-side index width, BW - B-side index width
// Signals : start, step, hold, trace_start, dir_valid, dir[1:0], abort (master -> slave)
//           i, i_t, index_a [AW], j, j_t, index_b [BW], busy, fill_done, trace_done (slave -> master)
// Modports: master - control FSM side, slave - index generator side
interface nw_seq_index_gen_if #(
   parameter int AW = 9,
   parameter int BW = 9
);
   logic          start;
   logic          step;
   logic          hold;
   logic          trace_start;
   logic          dir_valid;
   logic [1:0]    dir;
   logic          abort;
   logic [AW-1:0] i;
   logic [BW-1:0] j;
   logic [AW-1:0] i_t;
   logic [BW-1:0] j_t;
   logic [AW-1:0] index_a;
   logic [BW-1:0] index_b;
   logic          busy;
   logic          fill_done;
   logic          trace_done;

   modport master (
      output start, step, hold, trace_start, dir_valid, dir, abort,
      input  i, j, i_t, j_t, index_a, index_b, busy, fill_done, trace_done
   );

   modport slave (
      input  start, step, hold, trace_start, dir_valid, dir, abort,
      output i, j, i_t, j_t, index_a, index_b, busy, fill_done, trace_done
   );
endinterface

// File: rtl/nw_trace_counter.sv
// rtl/nw_trace_counter.sv - traceback row/column counters with border forcing
//
// Purpose : holds (i_t, j_t). load presets (N, M), clear zeroes both, en
//           applies one dir move. On row 0 every real move goes left; on
//           column 0 every real move goes up. Decrements saturate at 0.
// Ports   : clk, rst_n (async active-low)
//           load, clear, en, dir[1:0]  in
//           i_t[AW], j_t[BW]           out  counters
//           reach_origin               out  this enabled move lands on (0,0)
module nw_trace_counter
   import nw_pkg::*;
#(
   parameter int N  = 128,
   parameter int M  = 128,
   parameter int AW = 9,
   parameter int BW = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          clear,
   input  logic          en,
   input  logic [1:0]    dir,
   output logic [AW-1:0] i_t,
   output logic [BW-1:0] j_t,
   output logic          reach_origin
);
   logic [AW-1:0] i_t_d, i_t_q;
   logic [BW-1:0] j_t_d, j_t_q;
   logic          dec_i, dec_j;

   always_comb begin
      dec_i = 1'b0;
      dec_j = 1'b0;
      if (dir != DIR_NONE) begin
         if (i_t_q == '0) begin
            dec_j = 1'b1;
         end else if (j_t_q == '0) begin
            dec_i = 1'b1;
         end else begin
            // diag moves both, up moves row only, left moves column only
            dec_i = (dir != DIR_LEFT);
            dec_j = (dir != DIR_UP);
         end
      end
   end

   always_comb begin
      i_t_d = i_t_q;
      j_t_d = j_t_q;
      if (clear) begin
         i_t_d = '0;
         j_t_d = '0;
      end else if (load) begin
         i_t_d = AW'(N);
         j_t_d = BW'(M);
      end else if (en) begin
         if (dec_i && (i_t_q != '0)) i_t_d = i_t_q - AW'(1);
         if (dec_j && (j_t_q != '0)) j_t_d = j_t_q - BW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_t_q <= '0;
         j_t_q <= '0;
      end else begin
         i_t_q <= i_t_d;
         j_t_q <= j_t_d;
      end
   end

   assign reach_origin = en && !clear && !load &&
                         ((i_t_q != '0) || (j_t_q != '0)) &&
                         (i_t_d == '0) && (j_t_d == '0);
   assign i_t = i_t_q;
   assign j_t = j_t_q;
endmodule

// File: rtl/nw_seq_index_gen.sv
// rtl/nw_seq_index_gen.sv - A/B sequence RAM index generator with fill and traceback counters
//
// Purpose : owns the fill scan counters (i, j) and drives the A/B RAM read
//           indices from one FSM (IDLE, FILL, WAIT_TRACE, TRACE). Traceback
//           counters live in nw_trace_counter.
// Macro   : NW_INDEX_REG_EN - when defined, index_a/index_b are registered
//           (previous-cycle counter values); otherwise combinational.
// Ports   : clk, rst_n (async active-low)
//           bus (nw_seq_index_gen_if.slave): start, step, hold, trace_start,
//           dir_valid, dir, abort in; i, j, i_t, j_t, index_a, index_b,
//           busy, fill_done, trace_done out
module nw_seq_index_gen
   import nw_pkg::*;
#(
   parameter int N        = 128,
   parameter int M        = 128,
   parameter int BitAddrA = $clog2(N + 1),
   parameter int BitAddrB = $clog2(M + 1)
) (
   input logic                clk,
   input logic                rst_n,
   nw_seq_index_gen_if.slave  bus
);
   localparam int AW = BitAddrA + 1;
   localparam int BW = BitAddrB + 1;

   logic [1:0]    state_d, state_q;
   logic [AW-1:0] i_d, i_q;
   logic [BW-1:0] j_d, j_q;
   logic          fill_done_d, fill_done_q;
   logic          trace_done_d, trace_done_q;
   logic [AW-1:0] index_a_d;
   logic [BW-1:0] index_b_d;
   logic          tc_load, tc_clear, tc_en, tc_reach;
   logic [AW-1:0] i_t;
   logic [BW-1:0] j_t;
   logic          active;

   // abort beats hold, hold beats every state action
   assign active   = !bus.abort && !bus.hold;
   assign tc_clear = bus.abort;
   assign tc_load  = active && (state_q == WAIT_TRACE) && bus.trace_start;
   assign tc_en    = active && (state_q == TRACE) && bus.dir_valid;

   nw_trace_counter #(.N(N), .M(M), .AW(AW), .BW(BW)) u_trace_counter (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (tc_load),
      .clear        (tc_clear),
      .en           (tc_en),
      .dir          (bus.dir),
      .i_t          (i_t),
      .j_t          (j_t),
      .reach_origin (tc_reach)
   );

   always_comb begin
      state_d      = state_q;
      i_d          = i_q;
      j_d          = j_q;
      fill_done_d  = 1'b0;
      trace_done_d = 1'b0;
      if (bus.abort) begin
         state_d = IDLE;
         i_d     = '0;
         j_d     = '0;
      end else if (!bus.hold) begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d = FILL;
                  i_d     = AW'(1);
                  j_d     = BW'(1);
               end
            end
            FILL: begin
               if (bus.step) begin
                  if (j_q < BW'(M)) begin
                     j_d = j_q + BW'(1);
                  end else if (i_q < AW'(N)) begin
                     j_d = BW'(1);
                     i_d = i_q + AW'(1);
                  end else begin
                     // last cell: counters stay parked at (N, M)
                     fill_done_d = 1'b1;
                     state_d     = WAIT_TRACE;
                  end
               end
            end
            WAIT_TRACE: begin
               if (bus.trace_start) state_d = TRACE;
            end
            TRACE: begin
               if (tc_reach) begin
                  trace_done_d = 1'b1;
                  state_d      = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // address 0 is the gap row/column, safe to present outside the scans
   always_comb begin
      index_a_d = '0;
      index_b_d = '0;
      case (state_q)
         FILL: begin
            index_a_d = i_q;
            index_b_d = j_q;
         end
         TRACE: begin
            index_a_d = i_t;
            index_b_d = j_t;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         i_q          <= '0;
         j_q          <= '0;
         fill_done_q  <= 1'b0;
         trace_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         i_q          <= i_d;
         j_q          <= j_d;
         fill_done_q  <= fill_done_d;
         trace_done_q <= trace_done_d;
      end
   end

`ifdef NW_INDEX_REG_EN
   logic [AW-1:0] index_a_q;
   logic [BW-1:0] index_b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_a_q <= '0;
         index_b_q <= '0;
      end else begin
         index_a_q <= index_a_d;
         index_b_q <= index_b_d;
      end
   end

   assign bus.index_a = index_a_q;
   assign bus.index_b = index_b_q;
`else
   assign bus.index_a = index_a_d;
   assign bus.index_b = index_b_d;
`endif

   assign bus.i          = i_q;
   assign bus.j          = j_q;
   assign bus.i_t        = i_t;
   assign bus.j_t        = j_t;
   assign bus.busy       = (state_q != IDLE);
   assign bus.fill_done  = fill_done_q;
   assign bus.trace_done = trace_done_q;
endmodule

// File: tb/tb_nw_seq_index_gen.sv
// tb/tb_nw_seq_index_gen.sv - scoreboard bench for nw_seq_index_gen with N=4, M=3
module tb_nw_seq_index_gen;
   import nw_pkg::*;

   localparam int N  = 4;
   localparam int M  = 3;
   localparam int AW = 4;
   localparam int BW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nw_seq_index_gen_if #(.AW(AW), .BW(BW)) bus ();

   nw_seq_index_gen #(.N(N), .M(M)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string nm;
      int    busy, i, j, it, jt, ia, ib, fd, td;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   prev_a = 0;
   int   prev_b = 0;
   event chk_ev;

   task automatic chk(input string nm, input string f, input logic [31:0] act, input int want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s.%s actual=%0d required=%0d", nm, f, act, want);
      end
   endtask

   // monitor: one expectation per clock edge (or per immediate-check event)
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or chk_ev);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.nm, "busy",       32'(bus.busy),       e.busy);
            chk(e.nm, "i",          32'(bus.i),          e.i);
            chk(e.nm, "j",          32'(bus.j),          e.j);
            chk(e.nm, "i_t",        32'(bus.i_t),        e.it);
            chk(e.nm, "j_t",        32'(bus.j_t),        e.jt);
            chk(e.nm, "index_a",    32'(bus.index_a),    e.ia);
            chk(e.nm, "index_b",    32'(bus.index_b),    e.ib);
            chk(e.nm, "fill_done",  32'(bus.fill_done),  e.fd);
            chk(e.nm, "trace_done", 32'(bus.trace_done), e.td);
         end
      end
   end

   task automatic push(input string nm, input logic [1:0] st, input int i, j, it, jt, fd, td,
                       input bit is_reset);
      exp_t e;
      int   ma, mb;
      ma = (st == FILL) ? i : (st == TRACE) ? it : 0;
      mb = (st == FILL) ? j : (st == TRACE) ? jt : 0;
      e.nm = nm; e.busy = (st != IDLE) ? 1 : 0;
      e.i = i; e.j = j; e.it = it; e.jt = jt; e.fd = fd; e.td = td;
`ifdef NW_INDEX_REG_EN
      e.ia = is_reset ? 0 : prev_a;
      e.ib = is_reset ? 0 : prev_b;
      prev_a = ma;
      prev_b = mb;
`else
      e.ia = ma;
      e.ib = mb;
      if (is_reset) begin
         prev_a = 0;
         prev_b = 0;
      end
`endif
      sbq.push_back(e);
   endtask

   // drive one cycle of inputs at the falling edge and queue the post-edge state
   task automatic cyc(input string nm, input logic s, stp, h, ts, dv, input logic [1:0] d,
                      input logic ab, input logic [1:0] st, input int i, j, it, jt, fd, td);
      bus.start = s; bus.step = stp; bus.hold = h; bus.trace_start = ts;
      bus.dir_valid = dv; bus.dir = d; bus.abort = ab;
      push(nm, st, i, j, it, jt, fd, td, 1'b0);
      @(negedge clk);
   endtask

   task automatic reset_chk(input string nm);
      rst_n = 1'b0;
      push(nm, IDLE, 0, 0, 0, 0, 0, 0, 1'b1);
      ->chk_ev;
      @(negedge clk);
   endtask

   task automatic fill_steps(input string nm, input int from_k, input int to_k);
      for (int k = from_k; k <= to_k; k++)
         cyc(nm, 0, 1, 0, 0, 0, 2'b00, 0, FILL, k / M + 1, k % M + 1, 0, 0, 0, 0);
   endtask

   initial begin
      int waitc;
      bus.start = 0; bus.step = 0; bus.hold = 0; bus.trace_start = 0;
      bus.dir_valid = 0; bus.dir = 2'b00; bus.abort = 0;
      @(negedge clk);
      reset_chk("rst_state");
      rst_n = 1'b1;
      cyc("idle",        0, 0, 0, 0, 0, 2'b00, 0, IDLE, 0, 0, 0, 0, 0, 0);

      // pass 1: plain fill then diagonal traceback with forced final up move
      cyc("start1",      1, 0, 0, 0, 0, 2'b00, 0, FILL, 1, 1, 0, 0, 0, 0);
      fill_steps("fill1", 1, 11);
      cyc("fill1_done",  0, 1, 0, 0, 0, 2'b00, 0, WAIT_TRACE, 4, 3, 0, 0, 1, 0);
      cyc("wait1",       0, 0, 0, 0, 0, 2'b00, 0, WAIT_TRACE, 4, 3, 0, 0, 0, 0);
      cyc("tstart1",     0, 0, 0, 1, 0, 2'b00, 0, TRACE, 4, 3, 4, 3, 0, 0);
      cyc("diag1",       0, 0, 0, 0, 1, 2'b00, 0, TRACE, 4, 3, 3, 2, 0, 0);
      cyc("none",        0, 0, 0, 0, 1, 2'b11, 0, TRACE, 4, 3, 3, 2, 0, 0);
      cyc("diag2",       0, 0, 0, 0, 1, 2'b00, 0, TRACE, 4, 3, 2, 1, 0, 0);
      cyc("diag3",       0, 0, 0, 0, 1, 2'b00, 0, TRACE, 4, 3, 1, 0, 0, 0);
      cyc("forced_up",   0, 0, 0, 0, 1, 2'b00, 0, IDLE, 4, 3, 0, 0, 0, 1);
      cyc("post_trace1", 0, 0, 0, 0, 1, 2'b00, 0, IDLE, 4, 3, 0, 0, 0, 0);

      // pass 2: hold during fill and trace, left/up borders
      cyc("start2",      1, 0, 0, 0, 0, 2'b00, 0, FILL, 1, 1, 0, 0, 0, 0);
      fill_steps("fill2", 1, 4);
      for (int h = 0; h < 3; h++)
         cyc("hold_fill", 0, 1, 1, 0, 0, 2'b00, 0, FILL, 2, 2, 0, 0, 0, 0);
      fill_steps("fill2_resume", 5, 11);
      cyc("fill2_done",  0, 1, 0, 0, 0, 2'b00, 0, WAIT_TRACE, 4, 3, 0, 0, 1, 0);
      cyc("start_ign",   1, 0, 0, 0, 0, 2'b00, 0, WAIT_TRACE, 4, 3, 0, 0, 0, 0);
      cyc("tstart2",     0, 0, 0, 1, 0, 2'b00, 0, TRACE, 4, 3, 4, 3, 0, 0);
      cyc("left1",       0, 0, 0, 0, 1, 2'b10, 0, TRACE, 4, 3, 4, 2, 0, 0);
      cyc("left2",       0, 0, 0, 0, 1, 2'b10, 0, TRACE, 4, 3, 4, 1, 0, 0);
      cyc("left3",       0, 0, 0, 0, 1, 2'b10, 0, TRACE, 4, 3, 4, 0, 0, 0);
      cyc("hold_trace",  0, 0, 1, 0, 1, 2'b01, 0, TRACE, 4, 3, 4, 0, 0, 0);
      cyc("up1",         0, 0, 0, 0, 1, 2'b01, 0, TRACE, 4, 3, 3, 0, 0, 0);
      cyc("left_forced", 0, 0, 0, 0, 1, 2'b10, 0, TRACE, 4, 3, 2, 0, 0, 0);
      cyc("diag_forced", 0, 0, 0, 0, 1, 2'b00, 0, TRACE, 4, 3, 1, 0, 0, 0);
      cyc("up_hold",     0, 0, 1, 0, 1, 2'b01, 0, TRACE, 4, 3, 1, 0, 0, 0);
      cyc("up_last",     0, 0, 0, 0, 1, 2'b01, 0, IDLE, 4, 3, 0, 0, 0, 1);
      cyc("post_trace2", 0, 0, 0, 0, 0, 2'b00, 0, IDLE, 4, 3, 0, 0, 0, 0);

      // pass 3: trace_start ignored in FILL, abort at (3,1)
      cyc("start3",      1, 0, 0, 0, 0, 2'b00, 0, FILL, 1, 1, 0, 0, 0, 0);
      cyc("tstart_ign",  0, 1, 0, 1, 0, 2'b00, 0, FILL, 1, 2, 0, 0, 0, 0);
      fill_steps("fill3", 2, 6);
      cyc("abort",       0, 1, 0, 0, 0, 2'b00, 1, IDLE, 0, 0, 0, 0, 0, 0);
      cyc("post_abort",  0, 0, 0, 0, 0, 2'b00, 0, IDLE, 0, 0, 0, 0, 0, 0);

      // pass 4: asynchronous reset in the middle of a traceback
      cyc("start4",      1, 0, 0, 0, 0, 2'b00, 0, FILL, 1, 1, 0, 0, 0, 0);
      fill_steps("fill4", 1, 11);
      cyc("fill4_done",  0, 1, 0, 0, 0, 2'b00, 0, WAIT_TRACE, 4, 3, 0, 0, 1, 0);
      cyc("tstart4",     0, 0, 0, 1, 0, 2'b00, 0, TRACE, 4, 3, 4, 3, 0, 0);
      cyc("diag4",       0, 0, 0, 0, 1, 2'b00, 0, TRACE, 4, 3, 3, 2, 0, 0);
      reset_chk("async_rst");
      rst_n = 1'b1;
      cyc("after_rst",   0, 0, 0, 0, 1, 2'b00, 0, IDLE, 0, 0, 0, 0, 0, 0);

      waitc = 0;
      while (sbq.size() > 0 && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      if (sbq.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain pending=%0d required=0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
